iterative_divider: RTL and testbench
====================================

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  request; sampled only when busy=0.
REQ-004 SHALL have port: op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-005 SHALL have port: dividend  input  32  numerator operand.
REQ-006 SHALL have port: divisor  input  32  denominator operand.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-009 SHALL have port: result  output  32  quotient or remainder per op; held until next done.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after 32 iterations; DONE->RUN on start, else DONE->IDLE.
REQ-011 SHALL capture op, dividend, divisor at the edge that samples start (edge E0); inputs are don't-care afterwards.
REQ-012 SHALL perform one restoring shift/conditional-subtract iteration per cycle, 32 iterations on edges E1..E32.
REQ-013 SHALL register result and raise done on edge E33; done high exactly one cycle; latency fixed at 33 cycles for all ops and operand values.
REQ-014 SHALL drive busy=1 from E0 until E33; busy=0 in the done cycle.
REQ-015 SHALL ignore start while busy=1 (no restart, no corruption of the running operation).
REQ-016 SHALL accept start in the done cycle, giving back-to-back operations with no idle cycle.
REQ-017 SHALL, for DIV/REM, divide operand magnitudes unsigned; negate quotient if operand signs differ; remainder takes sign of dividend.
REQ-018 SHALL, for divisor=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
REQ-019 SHALL, for DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV result 0x80000000, REM result 0.
REQ-020 SHALL apply REQ-018/019 special cases without changing latency.
REQ-021 SHALL leave result unchanged between done pulses.

Reset
REQ-022 SHALL on rst=1 immediately force state IDLE, busy=0, done=0, result=0x00000000, internal iteration counter 0.
REQ-023 SHALL, on reset mid-operation, abort with no done pulse; first post-reset start behaves as from IDLE.
REQ-024 SHALL ignore start while rst=1.

Structure
REQ-025 SHALL take op encodings and the iteration count (32) from the shared processor constants include, also used by the ALU/decoder.
REQ-026 SHALL contain exactly one sub-module, div_sub_step: combinational 33-bit partial-remainder minus divisor, returning difference and borrow.
REQ-027 SHALL keep sign fix-up and special-case selection in iterative_divider, registered at E33.

Verification
REQ-028 SHALL cover: DIVU 100/7 -> result 14, done exactly 33 cycles after start edge; REMU 100/7 -> 2.
REQ-029 SHALL cover: DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 SHALL cover: divisor 0: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; each 33-cycle latency.
REQ-031 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-032 SHALL cover: start re-asserted with new operands at cycle 5 of RUN -> ignored, original result delivered at cycle 33; start in done cycle -> second result 33 cycles later.
REQ-033 SHALL cover: rst asserted at iteration 10 -> busy=0, result=0 immediately, no done; subsequent DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
// Shared divider constants: RV32M op encodings, iteration count, FSM states.
package iterative_divider_pkg;

    localparam int          DIV_ITERS = 32;
    localparam logic [5:0]  ITER_LOAD = 6'(DIV_ITERS);

    // op[1] selects remainder, op[0] selects unsigned
    localparam logic [1:0]  OP_DIV  = 2'b00;
    localparam logic [1:0]  OP_DIVU = 2'b01;
    localparam logic [1:0]  OP_REM  = 2'b10;
    localparam logic [1:0]  OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    // Two's-complement magnitude when the operand is to be treated as negative.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/iterative_divider_sub_step.sv
// One restoring-division step: 33-bit partial remainder minus divisor.
module div_sub_step (
    input  logic [32:0] i_partial,
    input  logic [31:0] i_divisor,
    output logic [32:0] o_diff,
    output logic        o_borrow
);

    logic [33:0] w_full;

    // Extended subtraction; the top bit is the borrow out.
    always_comb begin
        w_full   = {1'b0, i_partial} - {2'b00, i_divisor};
        o_diff   = w_full[32:0];
        o_borrow = w_full[33];
    end

endmodule

// File: rtl/iterative_divider.sv
// RV32M-style 32-bit iterative restoring divider, fixed 33-cycle latency.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | 32 shift/subtract iterations, then result fix-up
// S_DONE | result valid, done pulse; start here chains the next op
module iterative_divider
    import iterative_divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [31:0] r_dividend;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_partial;
    logic [32:0] w_diff;
    logic        w_borrow;
    logic        w_unused_diff_msb;
    logic [31:0] w_final;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_partial         = {r_rem, r_quo[31]};
    // After a non-borrowing subtract the difference is below the divisor, so bit 32 is always 0.
    assign w_unused_diff_msb = w_diff[32];

    div_sub_step u_sub_step (
        .i_partial (w_partial),
        .i_divisor (r_dvs),
        .o_diff    (w_diff),
        .o_borrow  (w_borrow)
    );

    // Operand sign handling at capture time (signed ops only).
    always_comb begin
        w_a_neg = ~op[0] & dividend[31];
        w_b_neg = ~op[0] & divisor[31];
    end

    // Sign fix-up and special-case selection for the final result.
    always_comb begin
        w_final = 32'h0000_0000;
        if (r_div_zero)
            w_final = r_is_rem ? r_dividend : 32'hFFFF_FFFF;
        else if (r_ovf)
            w_final = r_is_rem ? 32'h0000_0000 : 32'h8000_0000;
        else if (r_is_rem)
            w_final = r_neg_r ? (~r_rem + 32'd1) : r_rem;
        else
            w_final = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    end

    // Control FSM with iteration down-counter, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_dvs      <= 32'd0;
            r_dividend <= 32'd0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_cnt      <= ITER_LOAD;
                        r_rem      <= 32'd0;
                        r_quo      <= abs32(dividend, w_a_neg);
                        r_dvs      <= abs32(divisor, w_b_neg);
                        r_dividend <= dividend;
                        r_is_rem   <= op[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (divisor == 32'd0);
                        r_ovf      <= ~op[0] && (dividend == 32'h8000_0000)
                                              && (divisor == 32'hFFFF_FFFF);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_cnt == 6'd0) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_rem <= w_borrow ? w_partial[31:0] : w_diff[31:0];
                        r_quo <= {r_quo[30:0], ~w_borrow};
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed + random bench for iterative_divider with a result/latency scoreboard.
module tb_iterative_divider;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [31:0] last_exp = 32'd0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    iterative_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            DIV:     return $signed(a) / $signed(b);
            DIVU:    return a / b;
            REM:     return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest pending op in value and timing.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("result", result, e_mon.res);
                chk("latency", cyc, e_mon.due);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                last_exp = e_mon.res;
            end
        end
    end

    // Called at a negedge: drive one start for a single edge, then scramble inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_t e;
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        e.res = exp;
        e.due = cyc + 33;
        sb.push_back(e);
        start = 1'b0;
        op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        issue(o, a, b, exp);
        wait_done();
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned basics
        run(DIVU, 32'd100, 32'd7, 32'd14);
        run(REMU, 32'd100, 32'd7, 32'd2);

        // Signed
        run(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

        // Divide by zero
        run(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run(REMU, 32'd5, 32'd0, 32'd5);
        run(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);

        // Signed overflow
        run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Result held while idle
        repeat (5) @(negedge clk);
        chk("result_hold", result, last_exp);

        // start during RUN is ignored
        issue(DIVU, 32'd100, 32'd7, 32'd14);
        repeat (4) @(negedge clk);
        op = REMU; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Back-to-back: start in the done cycle
        run(DIVU, 32'd1000, 32'd10, 32'd100);
        run(REMU, 32'd1001, 32'd10, 32'd1);

        // Reset in the middle of an operation
        issue(DIVU, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF / 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_done",   {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("rst_ignores_start", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_abort_busy",   {31'd0, busy}, 32'd0);
        chk("post_abort_result", result, 32'd0);
        run(DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run(ro, ra, rb, model(ro, ra, rb));
        end

        repeat (5) @(negedge clk);
        chk("result_hold_end", result, last_exp);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
